// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared character-cell and 640x480 VGA timing constants
package vga_pkg;
  localparam int CHAR_W     = 8;
  localparam int CHAR_H     = 8;
  localparam int PIPE_LAT   = 3;
  localparam int RGB_BITS   = 6;
  localparam int CELL_SHIFT = $clog2(CHAR_W);

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
endpackage

// File: rtl/cursor_blink.sv
// rtl/cursor_blink.sv - counts vsync falling edges and toggles the cursor blink phase
module cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic blink_phase
);
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          vsync_prev;
  logic          vsync_fall;
  logic [CW-1:0] frame_cnt;

  assign vsync_fall = vsync_prev & ~vsync_in;

  // vsync_prev resets high so a low vsync right after reset reads as a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev  <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_fall) begin
        if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - three-stage character-cell pixel pipeline with blinking underline cursor
module text_renderer
  import vga_pkg::*;
#(
  parameter int                  COLS         = 80,
  parameter int                  ROWS         = 60,
  parameter int                  H_BITS       = 10,
  parameter int                  V_BITS       = 10,
  parameter int                  ADDR_BITS    = 13,
  parameter logic [RGB_BITS-1:0] FG_COLOR     = 6'h3F,
  parameter logic [RGB_BITS-1:0] BG_COLOR     = 6'h00,
  parameter int                  BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [H_BITS-1:0]    horicount,
  input  logic [V_BITS-1:0]    vertcount,
  input  logic                 visible_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic                 vram_en,
  output logic [ADDR_BITS-1:0] vram_addr,
  input  logic [7:0]           vram_data,
  output logic [10:0]          font_addr,
  input  logic [7:0]           font_data,
  input  logic                 cursor_en,
  input  logic [ADDR_BITS-1:0] cursor_addr,
  output logic [RGB_BITS-1:0]  rgb,
  output logic                 hsync_out,
  output logic                 vsync_out
);
  localparam int AW = ADDR_BITS + V_BITS + H_BITS;

  if (COLS * ROWS > (1 << ADDR_BITS)) begin : g_addr_check
    $error("text_renderer: COLS*ROWS does not fit in ADDR_BITS");
  end

  logic [ADDR_BITS-1:0] cell_addr;
  logic                 vis_d1, hs_d1, vs_d1, hit_d1;
  logic                 vis_d2, hs_d2, vs_d2, hit_d2;
  logic [2:0]           hcol_d1, vrow_d1, hcol_d2, vrow_d2;
  logic                 blink_phase;
  logic                 pix;

  assign cell_addr = ADDR_BITS'(AW'(vertcount >> CELL_SHIFT) * AW'(COLS)
                                + AW'(horicount >> CELL_SHIFT));

  // Memory-facing outputs are combinational so each memory's one-cycle read fits the 3-cycle budget
  assign vram_en   = rst_n & visible_in;
  assign vram_addr = rst_n ? cell_addr : '0;
  assign font_addr = rst_n ? {vram_data, vrow_d1} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_d1  <= 1'b0;
      hs_d1   <= 1'b1;
      vs_d1   <= 1'b1;
      hit_d1  <= 1'b0;
      hcol_d1 <= '0;
      vrow_d1 <= '0;
      vis_d2  <= 1'b0;
      hs_d2   <= 1'b1;
      vs_d2   <= 1'b1;
      hit_d2  <= 1'b0;
      hcol_d2 <= '0;
      vrow_d2 <= '0;
    end else begin
      vis_d1  <= visible_in;
      hs_d1   <= hsync_in;
      vs_d1   <= vsync_in;
      hit_d1  <= (cell_addr == cursor_addr);
      hcol_d1 <= horicount[2:0];
      vrow_d1 <= vertcount[2:0];
      vis_d2  <= vis_d1;
      hs_d2   <= hs_d1;
      vs_d2   <= vs_d1;
      hit_d2  <= hit_d1;
      hcol_d2 <= hcol_d1;
      vrow_d2 <= vrow_d1;
    end
  end

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_cursor_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync_in   (vsync_in),
    .blink_phase(blink_phase)
  );

  // Underline cursor occupies the bottom two glyph rows of the cell
  always_comb begin
    pix = font_data[~hcol_d2];
    if (hit_d2 && cursor_en && blink_phase && (vrow_d2 >= 3'd6)) begin
      pix = ~pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= vis_d2 ? (pix ? FG_COLOR : BG_COLOR) : '0;
      hsync_out <= hs_d2;
      vsync_out <= vs_d2;
    end
  end
endmodule

// File: tb/tb_text_renderer.sv
// tb/tb_text_renderer.sv - directed and randomized checks of text_renderer against a cell/glyph model
module tb_text_renderer;
  localparam int NH = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  horicount, vertcount;
  logic        visible_in, hsync_in, vsync_in;
  logic        vram_en;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [12:0] cursor_addr;
  logic [5:0]  rgb;
  logic        hsync_out, vsync_out;

  always #5 clk = ~clk;

  text_renderer dut (
    .clk(clk), .rst_n(rst_n), .horicount(horicount), .vertcount(vertcount),
    .visible_in(visible_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vram_en(vram_en), .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data), .cursor_en(cursor_en),
    .cursor_addr(cursor_addr), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  logic [7:0] vram [0:8191];
  logic [7:0] font [0:2047];
  always @(posedge clk) begin
    vram_data <= vram[vram_addr];
    font_data <= font[font_addr];
  end

  // Per-iteration record of what was driven and what the glyph lookup yields
  bit         h_vis [0:NH-1], h_hs [0:NH-1], h_vs [0:NH-1], h_pix [0:NH-1];
  bit         h_hit [0:NH-1], h_cen [0:NH-1], h_fav [0:NH-1];
  int         h_edges [0:NH-1];
  logic [2:0] h_vrow [0:NH-1];
  logic [7:0] h_ch [0:NH-1];
  logic [5:0] o_rgb [0:NH-1];
  bit         o_hs [0:NH-1], o_vs [0:NH-1];

  int          it = 3, checks = 0, errors = 0, edges = 0;
  bit          last_vs = 1'b1;
  bit          g_cen = 1'b0;
  logic [12:0] g_caddr = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_rgb(input int k);
    int j = k - 3;
    bit p;
    if (!h_vis[j]) return 6'h00;
    p = h_pix[j];
    if (h_hit[j] && h_cen[k-1] && ((h_edges[k-2] / 30) % 2 == 0) && h_vrow[j] >= 3'd6) p = !p;
    return p ? 6'h3F : 6'h00;
  endfunction

  task automatic set_idle(input int i);
    h_vis[i] = 0; h_hs[i] = 1; h_vs[i] = 1; h_pix[i] = 0; h_hit[i] = 0;
    h_cen[i] = 0; h_fav[i] = 0; h_edges[i] = 0; h_vrow[i] = '0; h_ch[i] = '0;
  endtask

  task automatic cyc(input bit vis, input bit hs, input bit vs, input int h, input int v);
    int addr;
    logic [7:0] ch, bits;
    @(negedge clk);
    o_rgb[it] = rgb; o_hs[it] = hsync_out; o_vs[it] = vsync_out;
    chk("rgb", 16'(rgb), 16'(exp_rgb(it)));
    chk("hsync_out", 16'(hsync_out), 16'(h_hs[it-3]));
    chk("vsync_out", 16'(vsync_out), 16'(h_vs[it-3]));
    if (h_fav[it-1]) chk("font_addr", 16'(font_addr), 16'({h_ch[it-1], h_vrow[it-1]}));
    visible_in = vis; hsync_in = hs; vsync_in = vs;
    horicount = h[9:0]; vertcount = v[9:0];
    cursor_en = g_cen; cursor_addr = g_caddr;
    addr = ((v / 8) * 80 + h / 8) % 8192;
    ch   = vram[addr];
    bits = font[{ch, 3'(v % 8)}];
    h_vis[it] = vis; h_hs[it] = hs; h_vs[it] = vs;
    h_pix[it] = bits[7 - (h % 8)];
    h_hit[it] = (addr == int'(g_caddr));
    h_cen[it] = g_cen; h_vrow[it] = 3'(v % 8); h_ch[it] = ch; h_fav[it] = 1;
    if (last_vs && !vs) edges++;
    last_vs = vs;
    h_edges[it] = edges;
    #1;
    chk("vram_en", 16'(vram_en), 16'(vis));
    chk("vram_addr", 16'(vram_addr), 16'(addr));
    it++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1, 1, 700, 490);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; visible_in = 1; hsync_in = 1; vsync_in = 1; horicount = 10'd700; vertcount = 10'd490;
    #1;
    chk("rst_rgb", 16'(rgb), 16'h0);
    chk("rst_hsync", 16'(hsync_out), 16'h1);
    chk("rst_vsync", 16'(vsync_out), 16'h1);
    chk("rst_vram_en", 16'(vram_en), 16'h0);
    chk("rst_vram_addr", 16'(vram_addr), 16'h0);
    chk("rst_font_addr", 16'(font_addr), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1; visible_in = 0;
    for (int i = it - 3; i <= it; i++) set_idle(i);
    edges = 0; last_vs = 1;
    it++;
  endtask

  task automatic draw_cell0(output int n);
    int base = it;
    for (int v = 0; v < 8; v++)
      for (int h = 0; h < 8; h++) cyc(1, 1, 1, h, v);
    idle(3);
    n = 0;
    for (int i = base + 3; i < base + 67; i++) if (o_rgb[i] == 6'h3F) n++;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc(0, 1, 0, 700, 490); cyc(0, 1, 0, 700, 490);
      cyc(0, 1, 1, 700, 490); cyc(0, 1, 1, 700, 490);
    end
  endtask

  initial begin
    int base, n, lows, first, last;
    rst_n = 0; visible_in = 0; hsync_in = 1; vsync_in = 1;
    horicount = '0; vertcount = '0; cursor_en = 0; cursor_addr = '0;
    for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) set_idle(i);
    do_reset();

    // Latency: cell 0 glyph row 0 = F0
    vram[0] = 8'h41; font[{8'h41, 3'd0}] = 8'hF0;
    base = it;
    for (int h = 0; h < 16; h++) cyc(1, 1, 1, h, 0);
    idle(3);
    for (int c = 3; c <= 10; c++) chk("latency", 16'(o_rgb[base+c]), (c <= 6) ? 16'h3F : 16'h00);

    // Address corner and first blank pixel (would be lit if visible)
    vram[4800] = 8'h7F; font[{8'h7F, 3'd7}] = 8'hFF;
    cyc(1, 1, 1, 639, 479);
    chk("corner_addr", 16'(vram_addr), 16'd4799);
    chk("corner_en", 16'(vram_en), 16'h1);
    base = it;
    cyc(0, 1, 1, 640, 479);
    chk("corner_off_en", 16'(vram_en), 16'h0);
    idle(3);
    chk("corner_rgb", 16'(o_rgb[base+3]), 16'h0);

    // Blanking override with solid glyphs
    for (int i = 0; i < 10; i++) vram[i] = 8'h7F;
    for (int r = 0; r < 8; r++) font[{8'h7F, 3'(r)}] = 8'hFF;
    base = it;
    for (int i = 0; i < 64; i++) cyc(0, 1, 1, i, i % 8);
    idle(3);
    n = 0;
    for (int i = base + 3; i < base + 67; i++) if (o_rgb[i] != 6'h00) n++;
    chk("blank_rgb", 16'(n), 16'd0);

    // Hsync alignment over one full line
    base = it;
    for (int h = 0; h < 800; h++) cyc(h < 640, !(h >= 656 && h < 752), 1, h, 10);
    idle(3);
    lows = 0; first = -1; last = -1;
    for (int i = base; i < base + 803; i++)
      if (!o_hs[i]) begin lows++; if (first < 0) first = i - base; last = i - base; end
    chk("hsync_width", 16'(lows), 16'd96);
    chk("hsync_first", 16'(first), 16'd659);
    chk("hsync_last", 16'(last), 16'd754);

    // Vsync alignment with a 2-cycle pulse
    base = it;
    for (int i = 0; i < 16; i++) cyc(0, 1, !(i >= 5 && i < 7), 700, 490);
    lows = 0; first = -1;
    for (int i = base; i < base + 16; i++)
      if (!o_vs[i]) begin lows++; if (first < 0) first = i - base; end
    chk("vsync_width", 16'(lows), 16'd2);
    chk("vsync_first", 16'(first), 16'd8);

    // Cursor blink on cell 0 with an empty glyph
    do_reset();
    vram[0] = 8'h20;
    for (int r = 0; r < 8; r++) font[{8'h20, 3'(r)}] = 8'h00;
    g_cen = 1; g_caddr = '0;
    draw_cell0(n); chk("cursor_on", 16'(n), 16'd16);
    frames(30);
    draw_cell0(n); chk("cursor_off", 16'(n), 16'd0);
    frames(30);
    draw_cell0(n); chk("cursor_on_again", 16'(n), 16'd16);
    frames(35);

    // Reset mid-line while a lit pixel and hsync pulse are on the outputs
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 40 + i, 0);
    chk("pre_rst_rgb", 16'(o_rgb[it-1]), 16'h3F);
    chk("pre_rst_hsync", 16'(o_hs[it-1]), 16'h0);
    do_reset();
    draw_cell0(n); chk("post_rst_cursor", 16'(n), 16'd16);
    frames(29);
    draw_cell0(n); chk("post_rst_29", 16'(n), 16'd16);
    frames(1);
    draw_cell0(n); chk("post_rst_30", 16'(n), 16'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4; i++) begin vram[i] = 8'($urandom); vram[80+i] = 8'($urandom); end
    for (int i = 0; i < 700; i++) begin
      int h, v;
      bit vis;
      g_cen   = ($urandom % 4) != 0;
      g_caddr = 13'($urandom_range(0, 3) + 80 * $urandom_range(0, 1));
      if ($urandom % 4 == 0) begin
        h = $urandom_range(0, 799); v = $urandom_range(0, 524);
        vis = (h < 640) && (v < 480);
      end else begin
        h = $urandom_range(0, 31); v = $urandom_range(0, 15);
        vis = ($urandom % 5) != 0;
      end
      cyc(vis, ($urandom % 4) != 0, ($urandom % 12) != 0, h, v);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_renderer.md
# text_renderer

Character-mode pixel pipeline that sits directly downstream of the VGA timing generator. It consumes the timing generator's raw `horicount`/`vertcount`/`visible`/`hsync`/`vsync` and fetches an 8-bit character code from video RAM, then the matching 8-pixel glyph row from font ROM. It serialises that row into RGB pixels and re-emits `hsync`/`vsync`, delayed by the same fixed latency so that colour and sync stay aligned at the DAC/connector. It also overlays a blinking underline cursor at a CPU-selected cell.

## Interface
- `COLS`, 80, character columns per row (640 px / 8).
- `ROWS`, 60, character rows per frame (480 px / 8).
- `H_BITS`, 10, width of `horicount`.
- `V_BITS`, 10, width of `vertcount`.
- `ADDR_BITS`, 13, VRAM address width; must satisfy COLS*ROWS ≤ 2^ADDR_BITS.
- `FG_COLOR`, 6'h3F, glyph-bit-1 colour (RRGGBB).
- `BG_COLOR`, 6'h00, glyph-bit-0 colour.
- `BLINK_FRAMES`, 30, frames per cursor blink phase.

Ports:
- `clk` in 1: pixel clock, the same clock as the timing generator.
- `rst_n` in 1: reset, asynchronous, active-low.
- `horicount` in H_BITS: current pixel column from the timing generator.
- `vertcount` in V_BITS: current line from the timing generator.
- `visible_in` in 1: the pixel is in the active region.
- `hsync_in` in 1: raw hsync, low during the pulse.
- `vsync_in` in 1: raw vsync, low during the pulse.
- `vram_en` out 1: VRAM read enable.
- `vram_addr` out ADDR_BITS: character cell address.
- `vram_data` in 8: character code, valid one cycle after the address.
- `font_addr` out 11: {char[7:0], glyph_row[2:0]}.
- `font_data` in 8: glyph row with bit 7 as the leftmost pixel, valid one cycle after the address.
- `cursor_en` in 1: cursor overlay enable.
- `cursor_addr` in ADDR_BITS: cell that carries the cursor.
- `rgb` out 6: registered pixel colour.
- `hsync_out` out 1: `hsync_in` delayed by PIPE_LAT.
- `vsync_out` out 1: `vsync_in` delayed by PIPE_LAT.

## Operation
- Stage 0 (cycle n):
  - `vram_addr` = (vertcount>>3)*COLS + (horicount>>3), truncated to ADDR_BITS. The multiply is by a constant and is combinational from the inputs.
  - `vram_en` = `visible_in`.
  - Register visible, sync, horicount[2:0], vertcount[2:0] and cursor_hit = (`vram_addr`==`cursor_addr`).
- Stage 1 (n+1): `font_addr` = {`vram_data`, vrow_d1}. Carry the stage-0 side signals forward one register.
- Stage 2 (n+2): pix = `font_data`[7 - hcol_d2].
  - If cursor_hit_d2 && `cursor_en` && blink_phase && vrow_d2 ≥ 6, invert pix.
- Output register (n+3):
  - `rgb` = visible_d2 ? (pix ? FG_COLOR : BG_COLOR) : 6'h00.
  - `hsync_out`/`vsync_out` = hsync_d2/vsync_d2.
- Blink counter:
  - Increments on each vsync_in falling edge (a registered previous value is kept).
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - The counter width is clog2(BLINK_FRAMES).
- Outside the visible region, `vram_addr` and `font_addr` are don't-care, but they must still be driven deterministically from the formula. `rgb` is forced to 0.
- `cursor_addr` and `cursor_en` are sampled every cycle with no synchronisation; the CPU side is on `clk`.

## Timing
- PIPE_LAT = 3. Pixel (h,v) appears on `rgb` exactly 3 cycles after `horicount`=h, `vertcount`=v. Both syncs carry the same 3-cycle delay, and pulse widths are preserved exactly.
- Reset values, applied asynchronously on `rst_n` low:
  - `rgb`=0, `hsync_out`=1, `vsync_out`=1, `vram_en`=0, `vram_addr`=0, `font_addr`=0.
  - All pipeline registers = 0, except the sync delay taps, which reset to 1.
  - Blink counter = 0, blink_phase = 1 (cursor shown).
- After reset release, the first 3 output cycles drain reset contents (`rgb` 0, syncs inactive), with no glitch pulse on either sync.
- Reset asserted mid-line or mid-frame: outputs go to reset values immediately, with no attempt to finish the line.
- Wrap at the end of a line or frame needs no special handling: the pipeline is address-driven each cycle.
- Simultaneous blink wrap and cursor pixel: the new blink_phase takes effect on the next cycle. A single-cycle mismatch at a frame boundary is acceptable because it falls in blanking.

## Structure
- Shared package `vga_pkg` holds:
  - CHAR_W=8, CHAR_H=8, PIPE_LAT=3, RGB_BITS=6.
  - The timing constants the timing generator already uses.
- Sub-module `cursor_blink` contains the vsync edge detect, frame counter and blink_phase. Its ports are `clk`, `rst_n`, `vsync_in` and `blink_phase`.
- The rest is a flat three-stage pipeline in `text_renderer`.

## Test plan
- Pixel latency:
  - Stimulus: VRAM[0]=0x41, font[{0x41,3'd0}]=0xF0, counters start at (0,0) with visible high.
  - Required: `rgb`=3F on cycles 3–6 and 00 on cycles 7–10.
- Sync alignment:
  - Stimulus: `hsync_in` low for cycles 656–751 of a line.
  - Required: `hsync_out` low for exactly cycles 659–754; check `vsync_out` the same way.
- Address corner:
  - Stimulus: `horicount`=639, `vertcount`=479.
  - Required: `vram_addr`=4799 and `vram_en`=1. At h=640, `vram_en`=0 and `rgb` is 0 three cycles later.
- Cursor blink:
  - Stimulus: `cursor_en`=1, `cursor_addr`=0, font row all zero.
  - Required: glyph rows 6–7 of cell 0 show 3F. After 30 vsync falling edges they show 00; after 30 more, 3F again.
- Blanking override:
  - Stimulus: `visible_in`=0 with `font_data`=0xFF.
  - Required: `rgb`=00 throughout.
- Reset mid-frame:
  - Stimulus: drop `rst_n` while `rgb`=3F and `hsync_out`=0.
  - Required: same cycle, `rgb`=0 and `hsync_out`=`vsync_out`=1. After release, blink_phase=1 and the counter restarts from 0.
